// File: rtl/pulse_train_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_pkg
// Description : Shared types and constants for the pulse train generator:
//               per-channel state encoding and the mode bit encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package pulse_train_pkg;

  // Per-channel sequencing state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } ch_state_e;

  // Encoding of the per-channel mode input
  localparam logic c_mode_oneshot = 1'b0;
  localparam logic c_mode_cont    = 1'b1;

  // Largest supported channel count
  localparam int c_max_ch = 16;

endpackage : pulse_train_pkg
`default_nettype wire

// File: rtl/pulse_train_ch.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_ch
// Description : One pulse channel. Latches duration/period/mode on an
//               accepted start, then produces a one-shot pulse or a
//               continuous HIGH/LOW train until stop or reset. Optional
//               burst limit when PULSE_TRAIN_GEN_BURST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_ch
  import pulse_train_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] duration,
  input  logic [CNT_W-1:0] period,
`ifdef PULSE_TRAIN_GEN_BURST_EN
  input  logic [CNT_W-1:0] burst_len,
`endif
  output logic             pulse,
  output logic             active,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

  ch_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;     // phase within the period, 1..P
  logic [CNT_W-1:0] dur_q, dur_d;     // latched high time
  logic [CNT_W-1:0] per_q, per_d;     // latched period
  logic             mode_q, mode_d;
  logic             pulse_q, pulse_d;
  logic             active_q, active_d;
  logic             cfg_err_q, cfg_err_d;
  logic             w_cfg_bad;
  logic             w_last_pulse;

`ifdef PULSE_TRAIN_GEN_BURST_EN
  logic [CNT_W-1:0] burst_q, burst_d;  // latched burst length, 0 = unlimited
  logic [CNT_W-1:0] bcnt_q, bcnt_d;    // completed pulses in this burst
`endif

  // Start is rejected for a zero high time or a high time beyond the period
  assign w_cfg_bad = (duration == '0) || (duration > period);

`ifdef PULSE_TRAIN_GEN_BURST_EN
  assign w_last_pulse = (burst_q != '0) && (bcnt_q == (burst_q - c_one));
`else
  assign w_last_pulse = 1'b0;
`endif

  // Next-state, counter and shadow-register update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dur_d     = dur_q;
    per_d     = per_q;
    mode_d    = mode_q;
    cfg_err_d = 1'b0;
`ifdef PULSE_TRAIN_GEN_BURST_EN
    burst_d   = burst_q;
    bcnt_d    = bcnt_q;
`endif

    case (state_q)
      IDLE: begin
        // stop in the same cycle cancels the start silently
        if (start && !stop) begin
          if (w_cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d = HIGH;
            cnt_d   = c_one;
            dur_d   = duration;
            per_d   = period;
            mode_d  = mode;
`ifdef PULSE_TRAIN_GEN_BURST_EN
            burst_d = burst_len;
            bcnt_d  = '0;
`endif
          end
        end
      end

      HIGH: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == dur_q) begin
          if (mode_q == c_mode_oneshot || w_last_pulse) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
`ifdef PULSE_TRAIN_GEN_BURST_EN
            if (burst_q != '0) begin
              bcnt_d = bcnt_q + c_one;
            end
`endif
            // P == D: no low phase, restart the high phase directly
            if (per_q == dur_q) begin
              cnt_d = c_one;
            end else begin
              state_d = LOW;
              cnt_d   = cnt_q + c_one;
            end
          end
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end

      LOW: begin
        if (stop) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == per_q) begin
          state_d = HIGH;
          cnt_d   = c_one;
        end else begin
          cnt_d = cnt_q + c_one;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    pulse_d  = (state_d == HIGH);
    active_d = (state_d != IDLE);
  end

  // State, counters, shadow registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      dur_q     <= '0;
      per_q     <= '0;
      mode_q    <= c_mode_oneshot;
      pulse_q   <= 1'b0;
      active_q  <= 1'b0;
      cfg_err_q <= 1'b0;
`ifdef PULSE_TRAIN_GEN_BURST_EN
      burst_q   <= '0;
      bcnt_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dur_q     <= dur_d;
      per_q     <= per_d;
      mode_q    <= mode_d;
      pulse_q   <= pulse_d;
      active_q  <= active_d;
      cfg_err_q <= cfg_err_d;
`ifdef PULSE_TRAIN_GEN_BURST_EN
      burst_q   <= burst_d;
      bcnt_q    <= bcnt_d;
`endif
    end
  end

  assign pulse   = pulse_q;
  assign active  = active_q;
  assign cfg_err = cfg_err_q;

endmodule : pulse_train_ch
`default_nettype wire

// File: rtl/pulse_train_gen.sv
`default_nettype none
// ============================================================================
// Module      : pulse_train_gen
// Description : NUM_CH independent pulse/pulse-train channels sharing one
//               clock. Configuration buses are packed CNT_W bits per channel.
//               Define PULSE_TRAIN_GEN_BURST_EN to add the burst_len input.
// Revision    : 1.0 - initial release
// ============================================================================
module pulse_train_gen
  import pulse_train_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       mode,
  input  logic [NUM_CH*CNT_W-1:0] duration,
  input  logic [NUM_CH*CNT_W-1:0] period,
`ifdef PULSE_TRAIN_GEN_BURST_EN
  input  logic [NUM_CH*CNT_W-1:0] burst_len,
`endif
  output logic [NUM_CH-1:0]       pulse,
  output logic [NUM_CH-1:0]       active,
  output logic [NUM_CH-1:0]       cfg_err
);

  // Channel i owns bit i of the control buses and field i of the packed buses
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pulse_train_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .start     (start[i]),
      .stop      (stop[i]),
      .mode      (mode[i]),
      .duration  (duration[i*CNT_W +: CNT_W]),
      .period    (period[i*CNT_W +: CNT_W]),
`ifdef PULSE_TRAIN_GEN_BURST_EN
      .burst_len (burst_len[i*CNT_W +: CNT_W]),
`endif
      .pulse     (pulse[i]),
      .active    (active[i]),
      .cfg_err   (cfg_err[i])
    );
  end : g_ch

endmodule : pulse_train_gen
`default_nettype wire
